bufferfile_req_ctrl: RTL

- Request front-end that sits directly upstream of the 16x8 buffer file.
- Accepts read/write requests on a valid/ready stream and queues them in order.
- Issues at most one access per cycle to the buffer file using explicit wren/rden strobes.
- Captures the buffer file's registered read data and returns it on a valid/ready response stream; response-slot credits guarantee that no read data is ever dropped.

---
 rtl/bufferfile_req_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bufferfile_req_ctrl.sv
// bufferfile_req_ctrl -- in-order request front-end for the 16x8 buffer file.
// Requests are queued, issued one per cycle as explicit wren/rden strobes,
// and read data is captured into a credit-protected response FIFO.
// Optional build macro: BUFFERFILE_REQ_CTRL_STATS_EN adds the wr_count/rd_count
// strobe counters (saturating at 16'hFFFF).

module bufferfile_req_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              bf_wren,
  output logic              bf_rden,
  output logic [ADDR_W-1:0] bf_addr,
  output logic [DATA_W-1:0] bf_wdata,
  input  logic [DATA_W-1:0] bf_rdata
`ifdef BUFFERFILE_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int RA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);
  localparam int CW = SA + 1;
  localparam logic [CW-1:0] CR_MAX = CW'(RSP_DEPTH);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t          req_mem [REQ_DEPTH];
  logic [RA:0]   req_wp, req_rp;
  logic          req_empty, req_full;
  logic          acc, push_req, pop_req;
  req_t          in_req, cand;
  logic          cand_vld, credit_ok, issue;
  logic [CW-1:0] credits;

  assign req_empty = (req_wp == req_rp);
  assign req_full  = (req_wp[RA] != req_rp[RA]) &&
                     (req_wp[RA-1:0] == req_rp[RA-1:0]);

  // Ready is purely a function of queue state; reset only masks it.
  assign req_ready = !reset && !req_full;
  assign acc       = req_valid && req_ready;

  assign in_req = '{we: req_we, addr: req_addr, data: req_wdata};

  // An empty queue lets the incoming request issue on its accept edge, which
  // is what gives the one-cycle accept-to-strobe latency.
  assign cand      = req_empty ? in_req : req_mem[req_rp[RA-1:0]];
  assign cand_vld  = req_empty ? acc : 1'b1;
  assign credit_ok = (credits < CR_MAX);
  assign issue     = cand_vld && (cand.we || credit_ok);
  assign push_req  = acc && !(req_empty && issue);
  assign pop_req   = !req_empty && issue;

  // Request FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      req_wp <= '0;
      req_rp <= '0;
    end else begin
      if (push_req) req_wp <= req_wp + 1'b1;
      if (pop_req)  req_rp <= req_rp + 1'b1;
    end
  end

  // Request FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push_req) req_mem[req_wp[RA-1:0]] <= in_req;
  end

  // ---------------------------------------------------------------------------
  // Issue stage: registered buffer-file strobes
  // ---------------------------------------------------------------------------
  logic              bf_wren_q, bf_rden_q;
  logic [ADDR_W-1:0] bf_addr_q;
  logic [DATA_W-1:0] bf_wdata_q;

  // At most one strobe per cycle; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      bf_wren_q  <= 1'b0;
      bf_rden_q  <= 1'b0;
      bf_addr_q  <= '0;
      bf_wdata_q <= '0;
    end else begin
      bf_wren_q <= issue &&  cand.we;
      bf_rden_q <= issue && !cand.we;
      if (issue)            bf_addr_q  <= cand.addr;
      if (issue && cand.we) bf_wdata_q <= cand.data;
    end
  end

  assign bf_wren  = !reset && bf_wren_q;
  assign bf_rden  = !reset && bf_rden_q;
  assign bf_addr  = reset ? '0 : bf_addr_q;
  assign bf_wdata = reset ? '0 : bf_wdata_q;

  // ---------------------------------------------------------------------------
  // Capture: buffer file data is valid the cycle after bf_rden
  // ---------------------------------------------------------------------------
  logic              rd_pend;
  logic [ADDR_W-1:0] cap_addr;

  // Remember the read address so a following issue cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      cap_addr <= '0;
    end else begin
      rd_pend <= bf_rden_q;
      if (bf_rden_q) cap_addr <= bf_addr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO (never full on push thanks to the credit check)
  // ---------------------------------------------------------------------------
  rsp_t        rsp_mem [RSP_DEPTH];
  logic [SA:0] rsp_wp, rsp_rp;
  logic        rsp_empty, rsp_pop;
  rsp_t        rsp_head;

  assign rsp_empty = (rsp_wp == rsp_rp);
  assign rsp_valid = !reset && !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rp[SA-1:0]];
  assign rsp_rdata = rsp_valid ? rsp_head.data : '0;
  assign rsp_addr  = rsp_valid ? rsp_head.addr : '0;

  // Response FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_wp <= '0;
      rsp_rp <= '0;
    end else begin
      if (rd_pend) rsp_wp <= rsp_wp + 1'b1;
      if (rsp_pop) rsp_rp <= rsp_rp + 1'b1;
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (rd_pend) rsp_mem[rsp_wp[SA-1:0]] <= '{addr: cap_addr, data: bf_rdata};
  end

  // ---------------------------------------------------------------------------
  // Credits: reads issued but not yet taken by the consumer
  // ---------------------------------------------------------------------------
  logic cr_inc, cr_dec;

  assign cr_inc = issue && !cand.we;
  assign cr_dec = rsp_pop;

  // Issue and pop together cancel; guards keep the count inside 0..RSP_DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= '0;
    end else if (cr_inc && !cr_dec && credits != CR_MAX) begin
      credits <= credits + 1'b1;
    end else if (!cr_inc && cr_dec && credits != '0) begin
      credits <= credits - 1'b1;
    end
  end

`ifdef BUFFERFILE_REQ_CTRL_STATS_EN
  // Saturating strobe counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (bf_wren_q && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (bf_rden_q && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
